// File: rtl/fb_data_sync_b2a.sv
`timescale 1ns/1ps
// Moves a DW-bit word from clkB to clkA over a four-phase req/ack handshake; outA_valid lands 3 clkA edges after req.
// No backpressure from A; B rejects requests while inB_busy and keeps a saturating drop count.
module fb_data_sync_b2a #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clkB,
  input  logic          resetB,
  input  logic          clkA,
  input  logic          resetA,
  input  logic          inB_valid,
  input  logic [DW-1:0] inB_data,
  output logic          inB_busy,
  output logic          inB_done,
  input  logic          inB_drop_clr,
  output logic [CW-1:0] inB_drop_cnt,
  output logic          outA_valid,
  output logic [DW-1:0] outA_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } stateB_t;

  stateB_t       stateB;
  stateB_t       stateBNext;
  logic          reqB;
  logic [DW-1:0] holdB;
  logic [1:0]    ackSyncB;
  logic          accept;
  logic          reject;
  logic          reqNext;
  logic          doneNext;

  logic [1:0]    reqSyncA;
  logic          reqSeenA;
  logic          ackA;
  logic          riseA;

  always_ff @(posedge clkB or negedge resetB) begin
    if (!resetB) begin
      stateB <= IDLE;
    end else begin
      stateB <= stateBNext;
    end
  end

  always_comb begin
    stateBNext = stateB;
    case (stateB)
      IDLE:    if (accept) stateBNext = REQ;
      REQ:     if (ackSyncB[1]) stateBNext = REL;
      REL:     if (!ackSyncB[1]) stateBNext = IDLE;
      default: stateBNext = IDLE;
    endcase
  end

  // A stale ack still in flight after a B-only reset keeps busy high.
  always_comb begin
    inB_busy = (stateB != IDLE) | ackSyncB[1];
    accept   = inB_valid & ~inB_busy;
    reject   = inB_valid & inB_busy;
    reqNext  = (stateBNext == REQ);
    doneNext = (stateB == REL) & ~ackSyncB[1];
  end

  always_ff @(posedge clkB or negedge resetB) begin
    if (!resetB) begin
      reqB         <= 1'b0;
      inB_done     <= 1'b0;
      ackSyncB     <= '0;
      holdB        <= '0;
      inB_drop_cnt <= '0;
    end else begin
      reqB     <= reqNext;
      inB_done <= doneNext;
      ackSyncB <= {ackSyncB[0], ackA};
      if (accept) begin
        holdB <= inB_data;
      end
      if (inB_drop_clr) begin
        inB_drop_cnt <= '0;
      end else if (reject && (inB_drop_cnt != '1)) begin
        inB_drop_cnt <= inB_drop_cnt + 1'b1;
      end
    end
  end

  // holdB is stable for the whole time req is high, so sampling it across domains is safe.
  assign riseA = reqSyncA[1] & ~reqSeenA;

  always_ff @(posedge clkA or negedge resetA) begin
    if (!resetA) begin
      reqSyncA   <= '0;
      reqSeenA   <= 1'b0;
      ackA       <= 1'b0;
      outA_valid <= 1'b0;
      outA_data  <= '0;
    end else begin
      reqSyncA   <= {reqSyncA[0], reqB};
      reqSeenA   <= reqSyncA[1];
      ackA       <= reqSyncA[1];
      outA_valid <= riseA;
      if (riseA) begin
        outA_data <= holdB;
      end
    end
  end

endmodule

// File: tb/tb_fb_data_sync_b2a.sv
`timescale 1ns/1ps
// Directed and randomized bench for fb_data_sync_b2a with a queue-based reference of accepted words.
module tb_fb_data_sync_b2a;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clkB = 1'b0;
  logic          clkA = 1'b0;
  logic          resetB;
  logic          resetA;
  logic          inB_valid;
  logic [DW-1:0] inB_data;
  logic          inB_busy;
  logic          inB_done;
  logic          inB_drop_clr;
  logic [CW-1:0] inB_drop_cnt;
  logic          outA_valid;
  logic [DW-1:0] outA_data;

  int halfB = 5;
  int halfA = 15;
  int errors = 0;
  int checks = 0;
  int validCnt = 0;
  int doneCnt = 0;
  int glitchCnt = 0;
  logic [DW-1:0] prevData = '0;
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] rxQ[$];

  fb_data_sync_b2a #(.DW(DW), .CW(CW)) dut (
    .clkB(clkB), .resetB(resetB), .clkA(clkA), .resetA(resetA),
    .inB_valid(inB_valid), .inB_data(inB_data), .inB_busy(inB_busy),
    .inB_done(inB_done), .inB_drop_clr(inB_drop_clr), .inB_drop_cnt(inB_drop_cnt),
    .outA_valid(outA_valid), .outA_data(outA_data)
  );

  initial forever #(halfB) clkB = ~clkB;
  initial forever #(halfA) clkA = ~clkA;

  // Receive-side monitor: records delivered words and flags data changing without valid.
  initial forever begin
    @(posedge clkA);
    #1;
    if (!resetA) begin
      prevData = outA_data;
    end else begin
      if (outA_valid === 1'b1) begin
        rxQ.push_back(outA_data);
        validCnt++;
      end else if (outA_data !== prevData) begin
        glitchCnt++;
      end
      prevData = outA_data;
    end
  end

  initial forever begin
    @(posedge clkB);
    #1;
    if (inB_done === 1'b1) doneCnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycB(input int n);
    repeat (n) @(negedge clkB);
  endtask

  // Called at a clkB negedge; drives one request cycle.
  task automatic pulseB(input logic [DW-1:0] d);
    inB_valid = 1'b1;
    inB_data  = d;
    @(negedge clkB);
    inB_valid = 1'b0;
    inB_data  = $urandom;
  endtask

  // Busy must stay high every cycle until the done cycle, where it must be low.
  task automatic waitDone(input string tag, input int budget);
    int cyc;
    int busyLow;
    cyc = 0;
    busyLow = 0;
    while (inB_done !== 1'b1 && cyc < budget) begin
      if (inB_busy !== 1'b1) busyLow++;
      @(negedge clkB);
      cyc++;
    end
    check({tag, " done-in-budget"}, 64'(cyc < budget), 64'(1));
    check({tag, " busy-before-done"}, 64'(busyLow), 64'(0));
    check({tag, " busy-at-done"}, 64'(inB_busy), 64'(0));
  endtask

  initial begin
    int vc;
    int dc;
    int cyc;
    int expDone;
    int sent;
    int stall;
    int dropsSeg;
    int busyErr;
    int doneErr;
    int r;
    int f;
    bit outstanding;
    logic [DW-1:0] d;

    resetB = 1'b0;
    resetA = 1'b0;
    inB_valid = 1'b0;
    inB_data = '0;
    inB_drop_clr = 1'b0;
    expDone = 0;
    cycB(3);
    check("rst busy", 64'(inB_busy), 64'(0));
    check("rst done", 64'(inB_done), 64'(0));
    check("rst dropcnt", 64'(inB_drop_cnt), 64'(0));
    check("rst outA_valid", 64'(outA_valid), 64'(0));
    check("rst outA_data", 64'(outA_data), 64'(0));
    @(negedge clkA);
    resetA = 1'b1;
    cycB(1);
    resetB = 1'b1;
    cycB(2);

    // Single transfer, one reject while busy, then a second transfer after done.
    pulseB(32'hDEADBEEF);
    expQ.push_back(32'hDEADBEEF);
    check("t1 busy-after-accept", 64'(inB_busy), 64'(1));
    cycB(2);
    pulseB(32'h12345678);
    waitDone("t1", 300);
    expDone++;
    cycB(1);
    check("t1 one-valid", 64'(validCnt), 64'(1));
    check("t1 word", 64'(rxQ[rxQ.size()-1]), 64'(32'hDEADBEEF));
    check("t1 one-done", 64'(doneCnt), 64'(expDone));
    check("t1 dropcnt", 64'(inB_drop_cnt), 64'(1));
    pulseB(32'hCAFEF00D);
    expQ.push_back(32'hCAFEF00D);
    waitDone("t2", 300);
    expDone++;
    cycB(5);
    check("t2 valids", 64'(validCnt), 64'(2));
    check("t2 word", 64'(rxQ[rxQ.size()-1]), 64'(32'hCAFEF00D));
    check("t2 dones", 64'(doneCnt), 64'(expDone));
    check("t2 dropcnt", 64'(inB_drop_cnt), 64'(1));
    inB_drop_clr = 1'b1;
    cycB(1);
    inB_drop_clr = 1'b0;
    check("t2 clr", 64'(inB_drop_cnt), 64'(0));

    // Hold A in reset so B stays busy while the drop counter is driven to saturation.
    resetA = 1'b0;
    pulseB(32'hA5A50001);
    expQ.push_back(32'hA5A50001);
    repeat (254) pulseB($urandom);
    check("t3 cnt254", 64'(inB_drop_cnt), 64'(254));
    pulseB($urandom);
    check("t3 cnt255", 64'(inB_drop_cnt), 64'(255));
    repeat (45) pulseB($urandom);
    check("t3 saturate", 64'(inB_drop_cnt), 64'(255));
    inB_drop_clr = 1'b1;
    pulseB($urandom);
    inB_drop_clr = 1'b0;
    check("t3 clr-with-drop", 64'(inB_drop_cnt), 64'(0));
    pulseB($urandom);
    check("t3 count-after-clr", 64'(inB_drop_cnt), 64'(1));
    inB_drop_clr = 1'b1;
    cycB(1);
    inB_drop_clr = 1'b0;
    check("t3 clr", 64'(inB_drop_cnt), 64'(0));
    check("t3 no-valid-in-resetA", 64'(validCnt), 64'(2));
    resetA = 1'b1;
    waitDone("t3", 300);
    expDone++;
    cycB(5);
    check("t3 word", 64'(rxQ[rxQ.size()-1]), 64'(32'hA5A50001));

    // resetB while B is still in REQ but A has already delivered and acked.
    vc = validCnt;
    dc = doneCnt;
    pulseB(32'h00000077);
    expQ.push_back(32'h00000077);
    cyc = 0;
    while (validCnt == vc && cyc < 200) begin
      cycB(1);
      cyc++;
    end
    check("t4 first-delivery", 64'(validCnt), 64'(vc + 1));
    resetB = 1'b0;
    cycB(3);
    check("t4 busy-in-reset", 64'(inB_busy), 64'(0));
    check("t4 done-in-reset", 64'(inB_done), 64'(0));
    resetB = 1'b1;
    cycB(25);
    check("t4 busy-settled", 64'(inB_busy), 64'(0));
    check("t4 no-dup-valid", 64'(validCnt), 64'(vc + 1));
    check("t4 no-done", 64'(doneCnt), 64'(dc));
    pulseB(32'h00000055);
    expQ.push_back(32'h00000055);
    waitDone("t4", 300);
    expDone = doneCnt + 1;
    cycB(5);
    check("t4 next-word", 64'(rxQ[rxQ.size()-1]), 64'(32'h00000055));
    check("t4 valids", 64'(validCnt), 64'(vc + 2));

    // resetA right after delivery, before the ack can reach B: word is delivered again.
    vc = validCnt;
    dc = doneCnt;
    pulseB(32'h0BADCAFE);
    expQ.push_back(32'h0BADCAFE);
    expQ.push_back(32'h0BADCAFE);
    cyc = 0;
    while (validCnt == vc && cyc < 100) begin
      @(posedge clkA);
      #2;
      cyc++;
    end
    check("t5 first-delivery", 64'(validCnt), 64'(vc + 1));
    resetA = 1'b0;
    @(negedge clkA);
    @(negedge clkA);
    resetA = 1'b1;
    @(negedge clkB);
    waitDone("t5", 400);
    cycB(10);
    check("t5 redelivered", 64'(validCnt), 64'(vc + 2));
    check("t5 one-done", 64'(doneCnt), 64'(dc + 1));
    check("t5 word", 64'(rxQ[rxQ.size()-1]), 64'(32'h0BADCAFE));
    expDone = dc + 1;

    // Randomized clock ratios, 10 segments of 100 back-to-back transfers.
    for (int seg = 0; seg < 10; seg++) begin
      r = $urandom_range(1, 7);
      f = $urandom_range(2, 4);
      if ($urandom_range(0, 1) == 1) begin
        halfB = f;
        halfA = f * r;
      end else begin
        halfA = f;
        halfB = f * r;
      end
      inB_drop_clr = 1'b1;
      cycB(1);
      inB_drop_clr = 1'b0;
      outstanding = 1'b0;
      sent = 0;
      stall = 0;
      dropsSeg = 0;
      busyErr = 0;
      doneErr = 0;
      while ((sent < 100 || outstanding) && stall < 400) begin
        if (inB_done === 1'b1) begin
          if (!outstanding) doneErr++;
          if (inB_busy !== 1'b0) busyErr++;
          outstanding = 1'b0;
          stall = 0;
        end else if (inB_busy !== outstanding) begin
          busyErr++;
        end
        if (!outstanding && sent < 100) begin
          d = $urandom;
          inB_valid = 1'b1;
          inB_data = d;
          expQ.push_back(d);
          outstanding = 1'b1;
          sent++;
          expDone++;
        end else if (outstanding && $urandom_range(0, 7) == 0) begin
          inB_valid = 1'b1;
          inB_data = $urandom;
          dropsSeg++;
        end else begin
          inB_valid = 1'b0;
        end
        @(negedge clkB);
        stall++;
      end
      inB_valid = 1'b0;
      cycB(3);
      check("rnd in-budget", 64'(stall < 400), 64'(1));
      check("rnd busy", 64'(busyErr), 64'(0));
      check("rnd spurious-done", 64'(doneErr), 64'(0));
      check("rnd dropcnt", 64'(inB_drop_cnt), 64'((dropsSeg > 255) ? 255 : dropsSeg));
    end

    cycB(20);
    check("end dones", 64'(doneCnt), 64'(expDone));
    check("end count", 64'(rxQ.size()), 64'(expQ.size()));
    for (int i = 0; i < rxQ.size() && i < expQ.size(); i++) begin
      check($sformatf("end word[%0d]", i), 64'(rxQ[i]), 64'(expQ[i]));
    end
    check("end data-stable", 64'(glitchCnt), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fb_data_sync_b2a.md
Name: fb_data_sync_b2a

Overview:
- Carries a DW-bit data word from the clkB domain to the clkA domain. Runs in the opposite direction to the existing single-bit level/ack feedback synchronizer.
- Uses a four-phase req/ack handshake. The clkB side holds the data word stable while req is high. The clkA side captures the word on the synchronized rising edge of req and echoes req back as ack.
- Used wherever controller status or config words must cross from the clkB domain into the clkA domain without multi-bit skew.

Parameters:
- DW, 32, data word width in bits.
- CW, 8, width of the saturating drop counter.

Ports:
- clkB  input  1  clkB-domain clock.
- resetB  input  1  clkB-domain reset, asynchronous, active-low.
- clkA  input  1  clkA-domain clock.
- resetA  input  1  clkA-domain reset, asynchronous, active-low.
- inB_valid  input  1  clkB single-cycle request to transfer inB_data.
- inB_data  input  DW  clkB word; sampled only in the cycle a request is accepted.
- inB_busy  output  1  clkB; high when a new request cannot be accepted.
- inB_done  output  1  clkB single-cycle pulse; handshake fully returned to idle.
- inB_drop_clr  input  1  clkB; synchronous clear of inB_drop_cnt.
- inB_drop_cnt  output  CW  clkB; saturating count of rejected requests.
- outA_valid  output  1  clkA single-cycle pulse; outA_data updated this cycle.
- outA_data  output  DW  clkA; last received word, held between transfers.

Behaviour:
- Reset values: inB_busy 0, inB_done 0, inB_drop_cnt 0, outA_valid 0, outA_data 0.
- Internal reset values: req 0, ack 0, all sync flops 0, B FSM in IDLE.
- Synchronizers: req to clkA is two flops on clkA (reset by resetA). ack to clkB is two flops on clkB (reset by resetB).
- inB_busy is combinational: (state != IDLE) | ack_sync_B.
- Accept rule: inB_valid & !inB_busy.
  - On accept, latch inB_data into the hold register, set req=1 and go to REQ, all on the same clkB edge.
- Reject rule: inB_valid & inB_busy.
  - Hold register is untouched.
  - inB_drop_cnt increments on the next edge and saturates at 2^CW-1.
- inB_drop_clr has priority over increment in the same cycle. A clear together with a drop in the same cycle gives a count of 0.
- B FSM:
  - IDLE: accept -> REQ.
  - REQ: req=1. When ack_sync_B==1 -> REL.
  - REL: req=0. When ack_sync_B==0 -> IDLE, and inB_done=1 for exactly one clkB cycle (registered, asserted in the first IDLE cycle).
- A side:
  - req_sync_A is registered into req_seen.
  - On rise (req_sync_A & !req_seen): outA_data <= hold register, outA_valid=1 for one cycle.
  - ack <= req_sync_A on every clkA edge.
- Latency:
  - outA_valid asserts 3 clkA edges after req rises (2 sync + 1 edge detect).
  - inB_done asserts at least 5 clkB edges plus 2 clkA round-trips after accept.
- Data stability: the hold register is constant from accept until the B FSM returns to IDLE. outA_data therefore never samples a changing word.
- Back-to-back: a new accept is legal in the IDLE cycle that carries inB_done, provided ack_sync_B==0.
- resetB alone mid-transfer:
  - req drops; the A side drops ack normally.
  - B returns to IDLE, but inB_busy stays high until ack_sync_B reads 0. This prevents a stale ack completing a new transfer.
  - No outA_valid is generated for any later word until a fresh accept occurs.
- resetA alone mid-transfer:
  - req_seen resets to 0. A pending req that is still high is re-detected after resetA releases and delivered once.
  - The transfer is not lost; B completes normally.
- outA_data changes only in cycles where outA_valid=1.

Test Plan:
- Single transfer, clkB 100 MHz, clkA 33 MHz, inB_data=0xDEADBEEF pulse -> exactly one outA_valid with outA_data=0xDEADBEEF; one inB_done; inB_busy high from the accept edge until the done cycle.
- Second inB_valid (0x12345678) while busy, then a third after done (0xCAFEF00D) -> inB_drop_cnt=1; A side sees only 0xDEADBEEF then 0xCAFEF00D.
- 300 rejected requests with CW=8 -> inB_drop_cnt saturates at 255. inB_drop_clr together with a reject in the same cycle -> count 0.
- resetB asserted while in REQ after ack seen -> no duplicate outA_valid; inB_busy stays 1 until ack_sync_B=0; next transfer 0x00000055 delivered correctly.
- resetA asserted between outA_valid and ack return -> after release, outA_valid pulses once more with the same word; B reaches inB_done exactly once.
- Random clock ratios 1:7 to 7:1 with 1000 back-to-back transfers -> scoreboard order and value match, no loss, no duplicates without resets.
